// File: rtl/if_id_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch push side, decode pop side,
// branch flush and queue status.
//
// Handshake: a push transfers when in_valid & in_ready at a rising edge; a pop
// transfers when out_valid & out_ready at a rising edge. in_ready depends only
// on queue state and flush, never on out_ready, and out_* never depend
// combinationally on in_*.
interface if_id_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_instruc;
  logic [WIDTH-1:0]         in_seq_PC;
  logic                     in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_instruc;
  logic [WIDTH-1:0]         out_seq_PC;
  logic                     out_ready;
  logic                     flush;
  logic                     halted;
  logic [$clog2(DEPTH):0]   count;

  // Fetch/decode/branch side of the queue.
  modport master (
    output in_valid, in_instruc, in_seq_PC, out_ready, flush,
    input  in_ready, out_valid, out_instruc, out_seq_PC, halted, count
  );

  // The queue itself.
  modport slave (
    input  in_valid, in_instruc, in_seq_PC, out_ready, flush,
    output in_ready, out_valid, out_instruc, out_seq_PC, halted, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a small FIFO of {instruction, PC+2} entries between
// fetch and decode. in_ready doubles as fetch's PC enable, so a full queue,
// a taken-branch flush or a fetched HALT all freeze the PC.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] NOP_INSTRUC = WIDTH'(16'h0800);

  logic [WIDTH-1:0] instruc_mem [DEPTH];
  logic [WIDTH-1:0] seq_pc_mem  [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic             halted_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             is_halt;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign is_halt = (q.in_instruc[WIDTH-1 -: 5] == 5'b00000);

  // Flush blocks the push in its own cycle so a branch-shadow fetch never lands.
  assign q.in_ready  = ~full & ~halted_q & ~q.flush;
  assign q.out_valid = ~empty;

  assign push = q.in_valid & q.in_ready;
  assign pop  = q.out_valid & q.out_ready;

  // Empty queue presents a NOP with a zero PC so decode sees a harmless bubble.
  assign q.out_instruc = empty ? NOP_INSTRUC : instruc_mem[head];
  assign q.out_seq_PC  = empty ? '0 : seq_pc_mem[head];
  assign q.halted      = halted_q;
  assign q.count       = count_q;

  // Entry storage; contents are don't-care until the occupancy count covers them.
  always_ff @(posedge clk) begin
    if (rst && !q.flush && push) begin
      instruc_mem[tail] <= q.in_instruc;
      seq_pc_mem[tail]  <= q.in_seq_PC;
    end
  end

  // Pointers, occupancy and the sticky HALT flag; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (q.flush) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (push && is_halt) begin
        halted_q <= 1'b1;
      end
    end
  end
endmodule
